tg_packet_ctrl: RTL and testbench

Byte-level packet controller for the ThinkGear serial stream. It sits between the RS-232 byte receiver and the game logic. It sequences sync detection, length check, payload walk, checksum verify and timeout recovery. It commits the raw EEG sample and the eSense values (attention, meditation, signal quality) only on a verified packet. It replaces ad-hoc header matching with one FSM that owns the whole byte stream.

---
 rtl/tg_pkg.sv | 11 +
 rtl/tg_rx_watchdog.sv | 17 +
 rtl/tg_packet_ctrl.sv | 118 +++++++++++
 tb/tb_tg_packet_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tg_pkg.sv
// tg_pkg: shared constants, FSM state and payload parse-phase encodings for the ThinkGear packet controller.
package tg_pkg;
   localparam logic [7:0] SYNC_BYTE  = 8'hAA;
   localparam logic [7:0] CODE_POOR  = 8'h02;
   localparam logic [7:0] CODE_ATT   = 8'h04;
   localparam logic [7:0] CODE_MED   = 8'h05;
   localparam logic [7:0] CODE_RAW   = 8'h80;
   localparam logic [7:0] EXCODE_MIN = 8'h80;
   typedef enum logic [2:0] {SYNC1, SYNC2, PLEN, PAYLOAD, CHK} state_t;
   typedef enum logic [1:0] {PH_CODE, PH_VLEN, PH_VAL} phase_t;
endpackage

// File: rtl/tg_rx_watchdog.sv
// tg_rx_watchdog: counts idle cycles while enabled; pulses expire when the count reaches limit.
module tg_rx_watchdog #(
   parameter int unsigned TW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          kick,
   input  logic [TW-1:0] limit,
   output logic          expire
);
   logic [TW-1:0] cnt;
   assign expire = enable && !kick && cnt == limit;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= (enable && !kick && !expire) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/tg_packet_ctrl.sv
// tg_packet_ctrl: ThinkGear byte-stream FSM committing raw/eSense values only on checksum-verified packets.
// Define TG_STATS_EN to add saturating good_cnt/err_cnt packet counters.
module tg_packet_ctrl
   import tg_pkg::*;
#(
   parameter int unsigned MAX_PLEN    = 169,
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned TW          = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_done,
   input  logic [7:0]  rx_byte,
   output logic        raw_valid,
   output logic [15:0] raw_data,
   output logic        esense_valid,
   output logic [7:0]  attention,
   output logic [7:0]  meditation,
   output logic [7:0]  signal_q,
   output logic        pkt_err,
   output logic        busy
`ifdef TG_STATS_EN
   ,
   output logic [15:0] good_cnt,
   output logic [15:0] err_cnt
`endif
);
   localparam logic [7:0]    MAX_B = 8'(MAX_PLEN);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);
   state_t     state;
   phase_t     phase;
   logic [7:0] rem, sum, code, vlen, vidx, raw_hi, raw_lo, att_s, med_s, poor_s;
   logic       f_raw, f_att, f_med, f_poor, bad, expire, good, good_evt, err_evt, plen_bad;

   assign busy     = state != SYNC1;
   assign good     = (~sum == rx_byte) && !bad;
   assign plen_bad = rx_byte == 8'd0 || rx_byte > MAX_B;
   assign good_evt = rx_done && state == CHK && good;
   assign err_evt  = expire || (rx_done && state == CHK && !good)
                   || (rx_done && state == PLEN && rx_byte != SYNC_BYTE && plen_bad);

   tg_rx_watchdog #(.TW(TW)) u_wd (
      .clk(clk), .rst(rst), .enable(busy), .kick(rx_done), .limit(LIMIT), .expire(expire)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= SYNC1; phase <= PH_CODE;
         rem <= '0; sum <= '0; code <= '0; vlen <= '0; vidx <= '0;
         raw_hi <= '0; raw_lo <= '0; att_s <= '0; med_s <= '0; poor_s <= '0;
         f_raw <= 1'b0; f_att <= 1'b0; f_med <= 1'b0; f_poor <= 1'b0; bad <= 1'b0;
         raw_valid <= 1'b0; raw_data <= '0; esense_valid <= 1'b0;
         attention <= '0; meditation <= '0; signal_q <= '0; pkt_err <= 1'b0;
      end else begin
         raw_valid    <= good_evt && f_raw;
         esense_valid <= good_evt && (f_att || f_med || f_poor);
         pkt_err      <= err_evt;
         if (good_evt) begin
            if (f_raw)  raw_data   <= {raw_hi, raw_lo};
            if (f_att)  attention  <= att_s;
            if (f_med)  meditation <= med_s;
            if (f_poor) signal_q   <= poor_s;
         end
         if (expire) state <= SYNC1;
         else if (rx_done) case (state)
            SYNC1: state <= rx_byte == SYNC_BYTE ? SYNC2 : SYNC1;
            SYNC2: state <= rx_byte == SYNC_BYTE ? PLEN : SYNC1;
            PLEN: if (rx_byte != SYNC_BYTE) begin
               state <= plen_bad ? SYNC1 : PAYLOAD;
               rem <= rx_byte; sum <= '0; phase <= PH_CODE; bad <= 1'b0;
               f_raw <= 1'b0; f_att <= 1'b0; f_med <= 1'b0; f_poor <= 1'b0;
            end
            PAYLOAD: begin
               sum <= sum + rx_byte;
               rem <= rem - 8'd1;
               if (rem == 8'd1) state <= CHK;
               case (phase)
                  PH_CODE: begin
                     code <= rx_byte; vidx <= '0; vlen <= 8'd1;
                     phase <= rx_byte >= EXCODE_MIN ? PH_VLEN : PH_VAL;
                     if (rem == 8'd1) bad <= 1'b1;
                  end
                  // rem still counts this byte, so vlen must fit in rem-1
                  PH_VLEN: begin
                     vlen <= rx_byte;
                     phase <= rx_byte == 8'd0 ? PH_CODE : PH_VAL;
                     if (rx_byte >= rem) bad <= 1'b1;
                  end
                  PH_VAL: begin
                     vidx <= vidx + 8'd1;
                     phase <= vidx == vlen - 8'd1 ? PH_CODE : PH_VAL;
                     if (code == CODE_RAW && vlen == 8'd2) begin
                        if (vidx == 8'd0) raw_hi <= rx_byte;
                        else begin raw_lo <= rx_byte; f_raw <= 1'b1; end
                     end
                     if (code == CODE_POOR) begin poor_s <= rx_byte; f_poor <= 1'b1; end
                     if (code == CODE_ATT)  begin att_s  <= rx_byte; f_att  <= 1'b1; end
                     if (code == CODE_MED)  begin med_s  <= rx_byte; f_med  <= 1'b1; end
                  end
                  default: phase <= PH_CODE;
               endcase
            end
            CHK: state <= SYNC1;
            default: state <= SYNC1;
         endcase
      end

`ifdef TG_STATS_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         good_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (good_evt && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
         if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
`endif
endmodule

// File: tb/tb_tg_packet_ctrl.sv
// tb_tg_packet_ctrl: directed and randomized packets checked against a packet-level reference model.
module tb_tg_packet_ctrl;
   localparam int TO = 40;
   logic clk = 1'b0, rst = 1'b0, rx_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic raw_valid, esense_valid, pkt_err, busy;
   logic [15:0] raw_data;
   logic [7:0] attention, meditation, signal_q;
`ifdef TG_STATS_EN
   logic [15:0] good_cnt, err_cnt;
`endif

   tg_packet_ctrl #(.MAX_PLEN(169), .TIMEOUT_CYC(TO), .TW(20)) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_byte(rx_byte),
      .raw_valid(raw_valid), .raw_data(raw_data), .esense_valid(esense_valid),
      .attention(attention), .meditation(meditation), .signal_q(signal_q),
      .pkt_err(pkt_err), .busy(busy)
`ifdef TG_STATS_EN
      , .good_cnt(good_cnt), .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vecs = 0, errs = 0;
   int mon_rv = 0, mon_ev = 0, mon_err = 0, tot_rv = 0, tot_ev = 0, tot_err = 0;
   logic [7:0] pk[$];
   logic [15:0] e_raw = '0;
   logic [7:0] e_att = '0, e_med = '0, e_poor = '0;
   logic e_rv, e_ev, e_err;

   always @(negedge clk) begin
      mon_rv  <= mon_rv + int'(raw_valid);
      mon_ev  <= mon_ev + int'(esense_valid);
      mon_err <= mon_err + int'(pkt_err);
   end

   initial begin
      #5_000_000;
      $display("FAIL sim_timeout: bench did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: parse the whole packet in pk from the ThinkGear rules, assuming the DUT starts idle.
   task automatic model();
      int i = 0, plen, j = 0, vl, st;
      logic [7:0] s = '0, code, a = '0, m = '0, p = '0;
      logic [15:0] r = '0;
      logic bad = 1'b0, fr = 1'b0, fa = 1'b0, fm = 1'b0, fp = 1'b0;
      e_rv = 1'b0; e_ev = 1'b0; e_err = 1'b0;
      while (i < pk.size() && pk[i] == 8'hAA) i++;
      plen = int'(pk[i]);
      if (plen == 0 || plen > 169) begin e_err = 1'b1; tot_err++; return; end
      for (int k = 0; k < plen; k++) s += pk[i+1+k];
      while (j < plen && !bad) begin
         code = pk[i+1+j];
         if (code >= 8'h80) begin
            if (j + 1 >= plen) begin bad = 1'b1; break; end
            vl = int'(pk[i+2+j]); st = j + 2;
         end else begin
            vl = 1; st = j + 1;
         end
         if (st + vl > plen) begin bad = 1'b1; break; end
         if (code == 8'h80 && vl == 2) begin fr = 1'b1; r = {pk[i+1+st], pk[i+2+st]}; end
         if (code == 8'h02) begin fp = 1'b1; p = pk[i+1+st]; end
         if (code == 8'h04) begin fa = 1'b1; a = pk[i+1+st]; end
         if (code == 8'h05) begin fm = 1'b1; m = pk[i+1+st]; end
         j = st + vl;
      end
      if (~s == pk[i+1+plen] && !bad) begin
         if (fr) e_raw = r;
         if (fa) e_att = a;
         if (fm) e_med = m;
         if (fp) e_poor = p;
         e_rv = fr; e_ev = fa | fm | fp;
      end else e_err = 1'b1;
      tot_rv += int'(e_rv); tot_ev += int'(e_ev); tot_err += int'(e_err);
   endtask

   task automatic send(input logic [7:0] b);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      rx_byte = b; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0; rx_byte = 8'($urandom);
   endtask

   task automatic run_pkt(input string tag);
      model();
      foreach (pk[k]) send(pk[k]);
      chk({tag, " raw_valid"}, 32'(raw_valid), 32'(e_rv));
      chk({tag, " esense_valid"}, 32'(esense_valid), 32'(e_ev));
      chk({tag, " pkt_err"}, 32'(pkt_err), 32'(e_err));
      chk({tag, " raw_data"}, 32'(raw_data), 32'(e_raw));
      chk({tag, " esense"}, {8'h00, attention, meditation, signal_q}, {8'h00, e_att, e_med, e_poor});
      chk({tag, " busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   // mode 0 good, 1 corrupt checksum, 2 truncated multi-byte value, 3 maximum length
   task automatic gen(input int mode);
      logic [7:0] pl[$];
      logic [7:0] s = '0;
      int n = $urandom_range(1, 4), v;
      if (mode == 3) begin
         pl.push_back(8'h83); pl.push_back(8'd167);
         repeat (167) pl.push_back(8'($urandom));
      end else for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 5))
            0: begin pl.push_back(8'h02); pl.push_back(8'($urandom)); end
            1: begin pl.push_back(8'h04); pl.push_back(8'($urandom)); end
            2: begin pl.push_back(8'h05); pl.push_back(8'($urandom)); end
            3: begin pl.push_back(8'h80); pl.push_back(8'h02); pl.push_back(8'($urandom)); pl.push_back(8'($urandom)); end
            4: begin pl.push_back(8'h16); pl.push_back(8'($urandom)); end
            default: begin
               v = $urandom_range(0, 3);
               pl.push_back(8'h83); pl.push_back(8'(v));
               repeat (v) pl.push_back(8'($urandom));
            end
         endcase
      end
      if (mode == 2) begin pl.push_back(8'h81); pl.push_back(8'd5); pl.push_back(8'($urandom)); end
      foreach (pl[k]) s += pl[k];
      pk.delete();
      pk.push_back(8'hAA); pk.push_back(8'hAA);
      if ($urandom_range(0, 3) == 0) pk.push_back(8'hAA);
      pk.push_back(8'(pl.size()));
      foreach (pl[k]) pk.push_back(pl[k]);
      pk.push_back(mode == 1 ? ~s ^ 8'($urandom_range(1, 255)) : ~s);
   endtask

   initial begin
      int n, r;
      repeat (3) @(posedge clk); #1;
      chk("reset data", {raw_data, attention, meditation}, 32'd0);
      chk("reset misc", {21'd0, signal_q, raw_valid, esense_valid, pkt_err}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset busy", 32'(busy), 32'd0);

      pk = {8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'hFF, 8'h38, 8'h46};
      run_pkt("raw");
      chk("raw fixed", 32'(raw_data), 32'hFF38);
      pk = {8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h00, 8'h11, 8'h47};
      run_pkt("bad chk");
      chk("bad chk hold", 32'(raw_data), 32'hFF38);
      pk = {8'hAA, 8'hAA, 8'h06, 8'h02, 8'h00, 8'h04, 8'h3C, 8'h05, 8'h28, 8'h90};
      run_pkt("esense");
      chk("esense fixed", {8'h00, attention, meditation, signal_q}, 32'h003C2800);
      pk = {8'hAA, 8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h00, 8'h64, 8'h19};
      run_pkt("extra sync");
      chk("extra sync fixed", 32'(raw_data), 32'h0064);
      pk = {8'hAA, 8'hAA, 8'h00};
      run_pkt("plen 0");
      pk = {8'hAA, 8'hAA, 8'hAB};
      run_pkt("plen 171");
      gen(3);
      run_pkt("plen 169");

      for (int k = 0; k < 60; k++) begin
         repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 169)));
         r = $urandom_range(0, 9);
         gen(r < 7 ? 0 : r < 9 ? 1 : 2);
         run_pkt("random");
      end

      pk = {8'hAA, 8'hAA, 8'h04, 8'h80};
      foreach (pk[k]) send(pk[k]);
      n = 0;
      while (!pkt_err && n < TO + 10) begin @(posedge clk); #1; n++; end
      tot_err++;
      chk("timeout err", 32'(pkt_err), 32'd1);
      chk("timeout window", 32'(n >= TO && n <= TO + 2), 32'd1);
      chk("timeout busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      pk = {8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'hFF, 8'h38, 8'h46};
      run_pkt("after timeout");

      pk = {8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02};
      foreach (pk[k]) send(pk[k]);
      #2 rst = 1'b0;
      #1;
      chk("midrst data", {raw_data, attention, meditation}, 32'd0);
      chk("midrst misc", {22'd0, signal_q, raw_valid, esense_valid, pkt_err, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      e_raw = '0; e_att = '0; e_med = '0; e_poor = '0;
      @(posedge clk); #1;
      chk("midrst busy", 32'(busy), 32'd0);
      pk = {8'hAA, 8'hAA, 8'h06, 8'h02, 8'h00, 8'h04, 8'h3C, 8'h05, 8'h28, 8'h90};
      run_pkt("after reset");

      repeat (2) @(posedge clk); #1;
      chk("total raw pulses", 32'(mon_rv), 32'(tot_rv));
      chk("total esense pulses", 32'(mon_ev), 32'(tot_ev));
      chk("total err pulses", 32'(mon_err), 32'(tot_err));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
